rfphoenix_gpr_bank: RTL and testbench
=====================================

Name: rfphoenix_gpr_bank

Overview:
Parametrised multithreaded general-purpose register file for the rfPhoenix core. It generalises read-port count, thread count, register count, data width and byte-lane count, and registers every read output. It adds a hardware clear sequencer: a full sweep after reset and a per-thread clear on request. It sits between decode/regfetch and writeback, one instance per core.

Parameters:
NRD, 5, number of read ports
NTHREADS, 4, hardware threads; TB = $clog2(NTHREADS)
NREGS, 64, registers per thread; RB = $clog2(NREGS)
WID, 128, register width in bits
NLANES, 4, write-enable lanes; lane width LW = WID/NLANES, must divide exactly

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
wr  in  NLANES  per-lane write enable
wthread  in  TB  write thread
wa  in  RB  write register number
i  in  WID  write data
rthread  in  TB  read thread, shared by all read ports
ra  in  NRD*RB  read register numbers; port k uses bits [k*RB +: RB]
o  out  NRD*WID  registered read data; port k uses bits [k*WID +: WID]
clr_req  in  1  single-cycle pulse requesting a thread clear
clr_thread  in  TB  thread to clear
rdy  out  1  high when the bank accepts writes and reads return valid data

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Storage: NTHREADS*NREGS entries of WID bits, indexed {thread, reg}. One write port, NRD read ports.
- Reset: state CLR_ALL; sweep counter = 0; rdy = 0; all o = 0.
- CLR_ALL: writes zero to entry cnt each cycle and increments cnt.
  - After entry NTHREADS*NREGS-1 is written, the next state is IDLE.
  - Total duration is NTHREADS*NREGS cycles; rdy rises on the following cycle.
- IDLE: rdy = 1.
  - Write: lane n of entry {wthread,wa} takes i[n*LW +: LW] when wr[n] = 1; other lanes hold their value.
  - Writes with wa == 0 are discarded.
- Thread clear: clr_req in IDLE -> state CLR_THR, cnt = 0, rdy = 0 from the next cycle.
  - Zeroes {clr_thread latched, cnt} for NREGS cycles, then returns to IDLE.
  - clr_req outside IDLE is ignored and not queued.
- While rdy = 0: all external writes are dropped and o is forced to 0. Upstream holds issue on !rdy.
- Read latency: 1 cycle. o[k] at edge t+1 reflects rthread/ra[k] sampled at edge t.
- Register 0 always reads all-zero, regardless of storage contents.
- Simultaneous clr_req and wr in IDLE: the write completes that cycle and the clear starts next cycle.
- rst mid-sweep (either sweep type) restarts CLR_ALL from cnt = 0.
- Counter widths: CLR_ALL counter is TB+RB bits; CLR_THR uses its low RB bits. No wrap past the final entry.

Optional Feature:
RFPHOENIX_GPR_BYPASS_EN
- Defined: write-to-read forwarding. If a read in cycle t addresses {wthread,wa} being written in cycle t (wa != 0, rdy = 1), o[k] at t+1 carries i for lanes with wr[n] = 1 and stored data for the other lanes.
- Undefined: a same-cycle read returns the pre-write value; the new value is visible one cycle later.
- r0 zeroing applies in both builds.

Decomposition:
- rfPhoenixPkg holds:
  - Tid, Regspec and Value typedefs.
  - Constants: NTHREADS, NREGS, NLANES.
  - Enum gpr_clr_state_t {CLR_ALL, IDLE, CLR_THR}.
- Sub-module rfphoenix_gpr_rdport, instantiated NRD times:
  - Address mux, r0 zeroing and optional bypass merge.
  - Output register cleared on rst or !rdy.
- Top level holds the storage array, write-lane logic and clear FSM.

Test Plan:
- Reset then idle: rdy = 0 for exactly 256 cycles (4*64), rises on cycle 257; a read of any {t,r} then returns 0.
- Lane write: write thread 2, r5 = 0x0123..EF with wr = 4'b1111, then i = all-ones with wr = 4'b0010. Reading r5 returns the original data with only lane 1 = 0xFFFFFFFF.
- r0 and multi-port: write r0 = 0xDEAD, then read r0 on all 5 ports in one cycle -> all 0. Read five distinct written regs in one cycle -> each port's value appears one cycle later.
- Bypass: same-cycle write of r7 = 0xAA..AA, wr = 4'b1111, and read of r7.
  - BYPASS_EN defined -> o = 0xAA..AA next cycle.
  - Undefined -> old value, then 0xAA..AA one cycle later.
- Thread clear: fill threads 0-3, pulse clr_req with clr_thread = 1.
  - rdy is low for 64 cycles; writes issued during that window are dropped.
  - Thread 1 then reads all 0; threads 0, 2 and 3 are intact.
- Reset mid-clear: assert rst 30 cycles into a thread clear -> rdy stays low for a full 256-cycle sweep, after which every entry reads 0.

Source files
------------

// File: rtl/rfphoenix_gpr_bank_pkg.sv
// rfPhoenix GPR bank shared types and constants.
// Default geometry of the multithreaded register file.
package rfphoenix_gpr_bank_pkg;

  localparam int NTHREADS = 4;
  localparam int NREGS    = 64;
  localparam int NLANES   = 4;
  localparam int NRD      = 5;
  localparam int WID      = 128;
  localparam int TB       = $clog2(NTHREADS);
  localparam int RB       = $clog2(NREGS);

  typedef logic [TB-1:0]  Tid;
  typedef logic [RB-1:0]  Regspec;
  typedef logic [WID-1:0] Value;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_THR
  } gpr_clr_state_t;

endpackage

// File: rtl/rfphoenix_gpr_bank_rdport.sv
// rfPhoenix GPR read port: address build, r0 zeroing, output register.
// Forwarding of the in-flight write is built with RFPHOENIX_GPR_BYPASS_EN.
module rfphoenix_gpr_rdport #(
  parameter int TB     = 2,
  parameter int RB     = 6,
  parameter int WID    = 128,
  parameter int NLANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [TB-1:0]    rthread,
  input  logic [RB-1:0]    ra,
  output logic [TB+RB-1:0] raddr,
  input  logic [WID-1:0]   rdata,
  output logic [WID-1:0]   o
`ifdef RFPHOENIX_GPR_BYPASS_EN
  ,
  input  logic             we,
  input  logic [NLANES-1:0] wr,
  input  logic [TB-1:0]    wthread,
  input  logic [RB-1:0]    wa,
  input  logic [WID-1:0]   i
`endif
);

  localparam int LW = WID / NLANES;

  logic [WID-1:0] rd_val;

  assign raddr = {rthread, ra};

`ifdef RFPHOENIX_GPR_BYPASS_EN
  logic hit;

  // Merge written lanes of a same-cycle write to the addressed entry.
  always_comb begin
    rd_val = rdata;
    hit    = we && ({wthread, wa} == raddr);
    for (int n = 0; n < NLANES; n++) begin
      if (hit && wr[n]) begin
        rd_val[n*LW +: LW] = i[n*LW +: LW];
      end
    end
  end
`else
  assign rd_val = rdata;
`endif

  // Registered read data; zero for r0 and whenever the bank is not ready.
  always_ff @(posedge clk) begin
    if (rst || !rdy || ra == '0) begin
      o <= '0;
    end else begin
      o <= rd_val;
    end
  end

endmodule

// File: rtl/rfphoenix_gpr_bank.sv
// rfPhoenix multithreaded GPR bank with clear sequencer.
// Option macro: RFPHOENIX_GPR_BYPASS_EN (write-to-read forwarding).
module rfphoenix_gpr_bank #(
  parameter  int NRD      = rfphoenix_gpr_bank_pkg::NRD,
  parameter  int NTHREADS = rfphoenix_gpr_bank_pkg::NTHREADS,
  parameter  int NREGS    = rfphoenix_gpr_bank_pkg::NREGS,
  parameter  int WID      = rfphoenix_gpr_bank_pkg::WID,
  parameter  int NLANES   = rfphoenix_gpr_bank_pkg::NLANES,
  localparam int TB       = $clog2(NTHREADS),
  localparam int RB       = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NLANES-1:0]  wr,
  input  logic [TB-1:0]      wthread,
  input  logic [RB-1:0]      wa,
  input  logic [WID-1:0]     i,
  input  logic [TB-1:0]      rthread,
  input  logic [NRD*RB-1:0]  ra,
  output logic [NRD*WID-1:0] o,
  input  logic               clr_req,
  input  logic [TB-1:0]      clr_thread,
  output logic               rdy
);

  import rfphoenix_gpr_bank_pkg::*;

  localparam int AW = TB + RB;
  localparam int LW = WID / NLANES;
  localparam int NENT = NTHREADS * NREGS;

  localparam logic [AW-1:0] ALL_LAST = AW'(NENT - 1);
  localparam logic [RB-1:0] REG_LAST = RB'(NREGS - 1);

  gpr_clr_state_t state;

  logic [AW-1:0]  cnt;
  logic [TB-1:0]  thr;
  logic [WID-1:0] mem [NENT];
  logic [AW-1:0]  clr_addr;
  logic           clr_en;
  logic           we;
  logic [AW-1:0]  raddr [NRD];
  logic [WID-1:0] rdata [NRD];

  assign clr_en   = (state != IDLE);
  assign clr_addr = (state == CLR_THR) ? {thr, cnt[RB-1:0]} : cnt;
  assign we       = rdy && !rst && (wa != '0);

  // Clear sequencer: full sweep after reset, per-thread sweep on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_ALL;
      cnt   <= '0;
      thr   <= '0;
      rdy   <= 1'b0;
    end else begin
      unique case (state)
        CLR_ALL: begin
          if (cnt == ALL_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state <= CLR_THR;
            cnt   <= '0;
            thr   <= clr_thread;
            rdy   <= 1'b0;
          end
        end
        CLR_THR: begin
          if (cnt[RB-1:0] == REG_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= CLR_ALL;
          cnt   <= '0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: sweep zeroing has priority, else lane-masked write.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (we) begin
      for (int n = 0; n < NLANES; n++) begin
        if (wr[n]) begin
          mem[{wthread, wa}][n*LW +: LW] <= i[n*LW +: LW];
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    assign rdata[k] = mem[raddr[k]];

    rfphoenix_gpr_rdport #(
      .TB     (TB),
      .RB     (RB),
      .WID    (WID),
      .NLANES (NLANES)
    ) u_rd (
      .clk     (clk),
      .rst     (rst),
      .rdy     (rdy),
      .rthread (rthread),
      .ra      (ra[k*RB +: RB]),
      .raddr   (raddr[k]),
      .rdata   (rdata[k]),
      .o       (o[k*WID +: WID])
`ifdef RFPHOENIX_GPR_BYPASS_EN
      ,
      .we      (we),
      .wr      (wr),
      .wthread (wthread),
      .wa      (wa),
      .i       (i)
`endif
    );
  end

endmodule

// File: tb/tb_rfphoenix_gpr_bank.sv
// Self-checking bench for rfphoenix_gpr_bank.
// Reference model: plain 4x64 array of 128-bit registers.
module tb_rfphoenix_gpr_bank;

  localparam int NRD = 5;
  localparam int WID = 128;
  localparam int LW  = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   wr;
  logic [1:0]   wthread;
  logic [5:0]   wa;
  logic [127:0] i;
  logic [1:0]   rthread;
  logic [29:0]  ra;
  logic [639:0] o;
  logic         clr_req;
  logic [1:0]   clr_thread;
  logic         rdy;

  logic [127:0] model [4][64];
  int tests;
  int fails;

  localparam logic [127:0] AA = {4{32'hAAAA_AAAA}};

  rfphoenix_gpr_bank dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .wthread    (wthread),
    .wa         (wa),
    .i          (i),
    .rthread    (rthread),
    .ra         (ra),
    .o          (o),
    .clr_req    (clr_req),
    .clr_thread (clr_thread),
    .rdy        (rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] merge(
    logic [127:0] old, logic [127:0] nw, logic [3:0] m);
    logic [127:0] r;
    r = old;
    for (int n = 0; n < 4; n++)
      if (m[n]) r[n*LW +: LW] = nw[n*LW +: LW];
    return r;
  endfunction

  // Expected read of {t,r} given the write currently on the inputs.
  function automatic logic [127:0] exp_read(logic [1:0] t, logic [5:0] r);
    logic [127:0] e;
    e = model[t][r];
`ifdef RFPHOENIX_GPR_BYPASS_EN
    if (wa != 0 && wthread == t && wa == r) e = merge(e, i, wr);
`endif
    if (r == 0) e = '0;
    return e;
  endfunction

  task automatic model_write();
    if (wa != 0) model[wthread][wa] = merge(model[wthread][wa], i, wr);
  endtask

  task automatic model_zero();
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 64; r++) model[t][r] = '0;
  endtask

  task automatic idle_in();
    wr = '0; wthread = '0; wa = '0; i = '0;
    rthread = '0; ra = '0; clr_req = 1'b0; clr_thread = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle_in();
    tick();
    tests++;
    if (rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_rdy got %b exp 0", rdy);
    end
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_o got %h exp 0", o[127:0]);
    end
    rst = 1'b0;
    n = 0;
    while (!rdy && n < 1000) begin
      tick();
      n++;
    end
    tests++;
    if (n != 256) begin
      fails++;
      $display("FAIL reset_sweep_len got %0d exp 256", n);
    end
    model_zero();
    for (int c = 0; c < 4; c++) begin
      rthread = 2'($urandom);
      ra = 30'($urandom);
      tick();
      tests++;
      if (o !== '0) begin
        fails++;
        $display("FAIL post_reset_read got %h exp 0", o[127:0]);
      end
    end
  endtask

  task automatic test_lane_write();
    wthread = 2; wa = 5; wr = 4'b1111;
    i = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    tick();
    model_write();
    i = '1; wr = 4'b0010;
    tick();
    model_write();
    wr = '0; rthread = 2; ra = '0; ra[5:0] = 5;
    tick();
    tests++;
    if (o[127:0] !== 128'h01234567_89ABCDEF_FFFFFFFF_76543210) begin
      fails++;
      $display("FAIL lane_write got %h", o[127:0]);
    end
  endtask

  task automatic test_r0_multiport();
    wthread = 0; wa = 0; wr = 4'b1111; i = 128'hDEAD;
    tick();
    model_write();
    wr = '0; rthread = 0; ra = '0;
    tick();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL r0_all_ports got %h exp 0", o[127:0]);
    end
    wthread = 3; wr = 4'b1111;
    for (int k = 0; k < NRD; k++) begin
      wa = 6'(10 + k);
      i = rnd128();
      tick();
      model_write();
    end
    wr = '0; wa = '0; rthread = 3;
    for (int k = 0; k < NRD; k++) ra[k*6 +: 6] = 6'(10 + k);
    tick();
    for (int k = 0; k < NRD; k++) begin
      tests++;
      if (o[k*WID +: WID] !== model[3][10+k]) begin
        fails++;
        $display("FAIL multiport[%0d] got %h exp %h",
                 k, o[k*WID +: WID], model[3][10+k]);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] e [NRD];
    for (int c = 0; c < 300; c++) begin
      wthread = 2'($urandom);
      wa = 6'($urandom);
      wr = 4'($urandom);
      i = rnd128();
      rthread = 2'($urandom);
      ra = 30'($urandom);
      if ($urandom_range(3) == 0) begin
        rthread = wthread;
        ra[5:0] = wa;
      end
      for (int k = 0; k < NRD; k++) e[k] = exp_read(rthread, ra[k*6 +: 6]);
      tick();
      model_write();
      for (int k = 0; k < NRD; k++) begin
        tests++;
        if (o[k*WID +: WID] !== e[k]) begin
          fails++;
          $display("FAIL random c%0d p%0d got %h exp %h",
                   c, k, o[k*WID +: WID], e[k]);
        end
      end
    end
    wr = '0;
  endtask

  task automatic test_bypass();
    logic [127:0] old;
    old = model[1][7];
    if (old == AA) begin
      wthread = 1; wa = 7; wr = 4'b1111; i = '0;
      tick();
      model_write();
      old = '0;
    end
    wthread = 1; wa = 7; wr = 4'b1111; i = AA;
    rthread = 1; ra = '0; ra[5:0] = 7;
    tick();
    model_write();
    wr = '0;
    tests++;
`ifdef RFPHOENIX_GPR_BYPASS_EN
    if (o[127:0] !== AA) begin
      fails++;
      $display("FAIL bypass_same got %h exp %h", o[127:0], AA);
    end
`else
    if (o[127:0] !== old) begin
      fails++;
      $display("FAIL bypass_same got %h exp %h", o[127:0], old);
    end
`endif
    tick();
    tests++;
    if (o[127:0] !== AA) begin
      fails++;
      $display("FAIL bypass_next got %h exp %h", o[127:0], AA);
    end
  endtask

  task automatic test_thread_clear();
    int low;
    wr = 4'b1111;
    for (int t = 0; t < 4; t++)
      for (int r = 1; r < 64; r++) begin
        wthread = 2'(t); wa = 6'(r); i = rnd128();
        tick();
        model_write();
      end
    clr_req = 1'b1; clr_thread = 1;
    wthread = 0; wa = 3; i = rnd128();
    tick();
    model_write();
    clr_req = 1'b0;
    rthread = 0; ra = '0; ra[5:0] = 3;
    low = 0;
    while (!rdy && low < 200) begin
      low++;
      wthread = 2; wa = 6'($urandom_range(63, 1)); i = rnd128();
      tick();
      tests++;
      if (o[127:0] !== '0) begin
        fails++;
        $display("FAIL clr_o_forced got %h exp 0", o[127:0]);
      end
    end
    wr = '0;
    tests++;
    if (low != 64) begin
      fails++;
      $display("FAIL clr_rdy_low got %0d exp 64", low);
    end
    for (int r = 0; r < 64; r++) model[1][r] = '0;
    for (int t = 0; t < 4; t++)
      for (int b = 0; b < 64; b += NRD) begin
        rthread = 2'(t);
        for (int k = 0; k < NRD; k++) ra[k*6 +: 6] = 6'(b + k);
        tick();
        for (int k = 0; k < NRD; k++) begin
          tests++;
          if (o[k*WID +: WID] !== model[t][(b+k)%64]) begin
            fails++;
            $display("FAIL clr_check t%0d r%0d got %h exp %h", t,
                     (b+k)%64, o[k*WID +: WID], model[t][(b+k)%64]);
          end
        end
      end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clr_req = 1'b1; clr_thread = 2;
    tick();
    clr_req = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!rdy && n < 1000) begin
      tick();
      n++;
    end
    tests++;
    if (n != 256) begin
      fails++;
      $display("FAIL midclr_sweep_len got %0d exp 256", n);
    end
    model_zero();
    for (int t = 0; t < 4; t++)
      for (int b = 0; b < 64; b += NRD) begin
        rthread = 2'(t);
        for (int k = 0; k < NRD; k++) ra[k*6 +: 6] = 6'(b + k);
        tick();
        for (int k = 0; k < NRD; k++) begin
          tests++;
          if (o[k*WID +: WID] !== model[t][(b+k)%64]) begin
            fails++;
            $display("FAIL midclr_check t%0d r%0d got %h exp %h", t,
                     (b+k)%64, o[k*WID +: WID], model[t][(b+k)%64]);
          end
        end
      end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_lane_write();
    test_r0_multiport();
    test_random();
    test_bypass();
    test_thread_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
